// File: rtl/qam_modulator.sv
// qam_modulator
// Streams input words through a bit accumulator and maps the top bits into
// Gray-coded BPSK / QPSK / 16QAM / 64QAM I/Q samples. The bit count, mode
// select, residual-bit flush and both ready/valid handshakes are handled here.
// Optional feature macro: QAM_PILOT_EN inserts a {+STEP, +STEP} pilot after
// every PILOT_PERIOD data symbols. Without it, only data symbols are produced.
module qam_modulator #(
    parameter int SIZE_INPUT_BIT  = 8,
    parameter int SIZE_OUTPUT_BIT = 32,
    parameter int STEP            = 1024,
    parameter int PILOT_PERIOD    = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [SIZE_INPUT_BIT-1:0]    i_data,
    input  logic                         i_valid_input,
    output logic                         o_ready,
    input  logic [1:0]                   i_mode,
    input  logic                         i_flush,
    output logic [2*SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                         o_valid_output,
    input  logic                         i_ready
);

    // The accumulator holds one word plus at most five leftover bits.
    localparam int ACC_W = SIZE_INPUT_BIT + 5;
    localparam int CNT_W = $clog2(ACC_W + 1);

    localparam logic [1:0] MODE_BPSK  = 2'd0;
    localparam logic [1:0] MODE_QPSK  = 2'd1;
    localparam logic [1:0] MODE_QAM16 = 2'd2;
    localparam logic [1:0] MODE_QAM64 = 2'd3;

    localparam logic signed [SIZE_OUTPUT_BIT-1:0] STEP_S = SIZE_OUTPUT_BIT'(STEP);

    // Gray-coded axis level: decode Gray to binary, then map to an odd level,
    // 2*bin - (2^n - 1), and scale it by STEP.
    function automatic logic signed [SIZE_OUTPUT_BIT-1:0] axis_level(
        input logic [2:0] gray_bits,
        input logic [1:0] nbits
    );
        logic [2:0]                        bin_v;
        logic signed [SIZE_OUTPUT_BIT-1:0] twice_v;
        logic signed [SIZE_OUTPUT_BIT-1:0] offset_v;
        bin_v[2] = gray_bits[2];
        bin_v[1] = gray_bits[2] ^ gray_bits[1];
        bin_v[0] = gray_bits[2] ^ gray_bits[1] ^ gray_bits[0];
        twice_v  = $signed({{(SIZE_OUTPUT_BIT-4){1'b0}}, bin_v, 1'b0});
        case (nbits)
            2'd1:    offset_v = SIZE_OUTPUT_BIT'(1);
            2'd2:    offset_v = SIZE_OUTPUT_BIT'(3);
            2'd3:    offset_v = SIZE_OUTPUT_BIT'(7);
            default: offset_v = SIZE_OUTPUT_BIT'(0);
        endcase
        return (twice_v - offset_v) * STEP_S;
    endfunction

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       mode_r;

    logic [CNT_W-1:0] k_s;
    logic             has_sym_s;
    logic             flush_sym_s;
    logic             out_free_s;
    logic             pilot_due_s;
    logic             load_pilot_s;
    logic             load_data_s;
    logic             accept_s;
    logic [CNT_W-1:0] take_s;
    logic [CNT_W-1:0] cnt_left_s;
    logic [ACC_W-1:0] acc_left_s;
    logic [ACC_W-1:0] word_pos_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [5:0]       sym_bits_s;
    logic signed [SIZE_OUTPUT_BIT-1:0] i_lvl_s;
    logic signed [SIZE_OUTPUT_BIT-1:0] q_lvl_s;

`ifdef QAM_PILOT_EN
    localparam int PCNT_W = $clog2(PILOT_PERIOD + 1);
    logic [PCNT_W-1:0] pilot_cnt_r;
`endif

    // Bits per symbol of the active mode.
    always_comb begin
        case (mode_r)
            MODE_BPSK:  k_s = CNT_W'(1);
            MODE_QPSK:  k_s = CNT_W'(2);
            MODE_QAM16: k_s = CNT_W'(4);
            MODE_QAM64: k_s = CNT_W'(6);
            default:    k_s = CNT_W'(1);
        endcase
    end

    // Pilot request: a pilot wins the next free output slot once the period is reached.
    always_comb begin
`ifdef QAM_PILOT_EN
        pilot_due_s = (pilot_cnt_r == PCNT_W'(PILOT_PERIOD));
`else
        pilot_due_s = 1'b0;
`endif
    end

    // Handshake, emit/flush decisions and next accumulator contents.
    always_comb begin
        has_sym_s    = (cnt_r >= k_s);
        flush_sym_s  = i_flush & (cnt_r != {CNT_W{1'b0}}) & ~has_sym_s;
        out_free_s   = ~o_valid_output | i_ready;
        load_pilot_s = out_free_s & pilot_due_s;
        load_data_s  = out_free_s & ~pilot_due_s & (has_sym_s | flush_sym_s);
        o_ready      = ~has_sym_s & ~i_flush;
        accept_s     = i_valid_input & o_ready;

        // A flush consumes only the held bits; the zero padding comes from the
        // accumulator, whose bits below the held ones are always zero.
        if (load_data_s) begin
            if (has_sym_s) begin
                take_s = k_s;
            end else begin
                take_s = cnt_r;
            end
        end else begin
            take_s = {CNT_W{1'b0}};
        end

        cnt_left_s = cnt_r - take_s;
        acc_left_s = acc_r << take_s;
        word_pos_s = {i_data, {(ACC_W-SIZE_INPUT_BIT){1'b0}}} >> cnt_left_s;

        if (accept_s) begin
            acc_next_s = acc_left_s | word_pos_s;
            cnt_next_s = cnt_left_s + CNT_W'(SIZE_INPUT_BIT);
        end else begin
            acc_next_s = acc_left_s;
            cnt_next_s = cnt_left_s;
        end
    end

    // Split the top bits of the accumulator into I and Q levels for the active mode.
    always_comb begin
        sym_bits_s = acc_r[ACC_W-1 -: 6];
        case (mode_r)
            MODE_BPSK: begin
                i_lvl_s = axis_level({2'b00, sym_bits_s[5]}, 2'd1);
                q_lvl_s = {SIZE_OUTPUT_BIT{1'b0}};
            end
            MODE_QPSK: begin
                i_lvl_s = axis_level({2'b00, sym_bits_s[5]}, 2'd1);
                q_lvl_s = axis_level({2'b00, sym_bits_s[4]}, 2'd1);
            end
            MODE_QAM16: begin
                i_lvl_s = axis_level({1'b0, sym_bits_s[5:4]}, 2'd2);
                q_lvl_s = axis_level({1'b0, sym_bits_s[3:2]}, 2'd2);
            end
            MODE_QAM64: begin
                i_lvl_s = axis_level(sym_bits_s[5:3], 2'd3);
                q_lvl_s = axis_level(sym_bits_s[2:0], 2'd3);
            end
            default: begin
                i_lvl_s = {SIZE_OUTPUT_BIT{1'b0}};
                q_lvl_s = {SIZE_OUTPUT_BIT{1'b0}};
            end
        endcase
    end

    // Accumulator and held-bit count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    // Active mode changes only at a symbol boundary with nothing held.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mode_r <= MODE_BPSK;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
            mode_r <= i_mode;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Output register: pilot, data symbol, drained, or held under backpressure.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_data         <= {(2*SIZE_OUTPUT_BIT){1'b0}};
            o_valid_output <= 1'b0;
        end else if (load_pilot_s) begin
            o_data         <= {STEP_S, STEP_S};
            o_valid_output <= 1'b1;
        end else if (load_data_s) begin
            o_data         <= {i_lvl_s, q_lvl_s};
            o_valid_output <= 1'b1;
        end else if (i_ready) begin
            o_data         <= o_data;
            o_valid_output <= 1'b0;
        end else begin
            o_data         <= o_data;
            o_valid_output <= o_valid_output;
        end
    end

`ifdef QAM_PILOT_EN
    // Count emitted data symbols (flush symbols included); a pilot restarts the count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pilot_cnt_r <= {PCNT_W{1'b0}};
        end else if (load_pilot_s) begin
            pilot_cnt_r <= {PCNT_W{1'b0}};
        end else if (load_data_s) begin
            pilot_cnt_r <= pilot_cnt_r + PCNT_W'(1);
        end else begin
            pilot_cnt_r <= pilot_cnt_r;
        end
    end
`endif

endmodule
